// File: rtl/dmem_access_arbiter.sv
// Single owner of the byte-lane data memory port: arbitrates pipeline LSU (P) against a word-only
// DMA/debug master (D), builds byte enables / replicated store data, and extracts + extends loads.
module dmem_access_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p_req,
  input  logic        p_we,
  input  logic [1:0]  p_size,
  input  logic        p_unsigned,
  input  logic [31:0] p_addr,
  input  logic [31:0] p_wdata,
  output logic        p_gnt,
  output logic        p_rvalid,
  output logic [31:0] p_rdata,
  output logic        p_misalign,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {S_PIPE, S_DMA} state_t;

  localparam logic [3:0] STARVE_LIM  = 4'(STARVE_MAX);
  localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

  state_t      state, state_nxt;
  logic [3:0]  starve_cnt, starve_nxt;
  logic        d_wait;
  logic        p_mis;
  logic [3:0]  p_be;
  logic [31:0] p_wd;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] p_ld;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^d_addr[1:0];

  // P wins by default; the S_DMA slot hands D priority for exactly one grant.
  always_comb begin
    p_gnt = 1'b0;
    d_gnt = 1'b0;
    if (state == S_DMA) begin
      if (d_req)      d_gnt = 1'b1;
      else if (p_req) p_gnt = 1'b1;
    end else begin
      if (p_req)      p_gnt = 1'b1;
      else if (d_req) d_gnt = 1'b1;
    end
  end

  assign d_wait = d_req & ~d_gnt;

  always_comb begin
    starve_nxt = starve_cnt;
    state_nxt  = state;
    if (!d_wait)
      starve_nxt = '0;
    else if (starve_cnt < STARVE_LIM)
      starve_nxt = starve_cnt + 4'd1;
    case (state)
      S_PIPE:  if (d_wait && starve_cnt == STARVE_LAST) state_nxt = S_DMA;
      S_DMA:   if (d_gnt || !d_req) state_nxt = S_PIPE;
      default: state_nxt = S_PIPE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_PIPE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Byte-lane enables and replicated store data; size 2'b11 behaves as a word.
  always_comb begin
    p_mis = 1'b0;
    p_be  = 4'b0000;
    p_wd  = '0;
    case (p_size)
      2'b00: begin
        p_be = 4'b0001 << p_addr[1:0];
        p_wd = {4{p_wdata[7:0]}};
      end
      2'b01: begin
        p_mis = p_addr[0];
        p_be  = 4'b0011 << {p_addr[1], 1'b0};
        p_wd  = {2{p_wdata[15:0]}};
      end
      default: begin
        p_mis = |p_addr[1:0];
        p_be  = 4'b1111;
        p_wd  = p_wdata;
      end
    endcase
  end

  always_comb begin
    ld_b = mem_rdata[{p_addr[1:0], 3'b000} +: 8];
    ld_h = p_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (p_size)
      2'b00:   p_ld = p_unsigned ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
      2'b01:   p_ld = p_unsigned ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: p_ld = mem_rdata;
    endcase
  end

  // Misaligned P accesses are granted but never reach the memory write lanes.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 4'b0000;
    if (p_gnt) begin
      mem_addr = p_addr;
      if (p_we && !p_mis) begin
        mem_we    = p_be;
        mem_wdata = p_wd;
      end
    end else if (d_gnt) begin
      mem_addr = {d_addr[31:2], 2'b00};
      if (d_we) begin
        mem_we    = 4'b1111;
        mem_wdata = d_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_rvalid   <= 1'b0;
      p_misalign <= 1'b0;
      p_rdata    <= '0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
    end else begin
      p_rvalid   <= p_gnt;
      p_misalign <= p_gnt & p_mis;
      if (p_gnt)
        p_rdata <= (p_mis || p_we) ? 32'h0 : p_ld;
      d_rvalid <= d_gnt & ~d_we;
      if (d_gnt && !d_we)
        d_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Self-checking bench for dmem_access_arbiter: word memory model behind the port, scoreboard
// queues of expected P/D responses pushed at grant and popped when rvalid pulses.
module tb_dmem_access_arbiter;

  localparam int STARVE_MAX = 4;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_we;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } p_op_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
  } p_exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_req, p_we, p_unsigned;
  logic [1:0]  p_size;
  logic [31:0] p_addr, p_wdata;
  logic        p_gnt, p_rvalid, p_misalign;
  logic [31:0] p_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;

  logic [31:0] tbmem [0:255];
  logic [31:0] merged;

  p_exp_t      p_q[$];
  logic [31:0] d_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  dmem_access_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_req(p_req), .p_we(p_we), .p_size(p_size), .p_unsigned(p_unsigned),
    .p_addr(p_addr), .p_wdata(p_wdata), .p_gnt(p_gnt), .p_rvalid(p_rvalid),
    .p_rdata(p_rdata), .p_misalign(p_misalign),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Async-read, byte-write memory model
  assign mem_rdata = tbmem[mem_addr[9:2]];

  always_comb begin
    merged = mem_rdata;
    for (int b = 0; b < 4; b++)
      if (mem_we[b]) merged[8*b +: 8] = mem_wdata[8*b +: 8];
  end

  always @(posedge clk)
    if (|mem_we) tbmem[mem_addr[9:2]] <= merged;

  function automatic p_op_t mk(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] ew, input logic [31:0] ewd,
                               input logic [31:0] erd, input logic emis);
    p_op_t op;
    op.we = we; op.size = size; op.uns = uns; op.addr = addr; op.wdata = wdata;
    op.exp_we = ew; op.exp_wd = ewd; op.exp_rd = erd; op.exp_mis = emis;
    return op;
  endfunction

  task automatic idle_inputs();
    p_req = 1'b0; p_we = 1'b0; p_size = 2'b00; p_unsigned = 1'b0;
    p_addr = '0; p_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic drive_p(input p_op_t op);
    p_req = 1'b1; p_we = op.we; p_size = op.size; p_unsigned = op.uns;
    p_addr = op.addr; p_wdata = op.wdata;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({p_rvalid, d_rvalid, p_misalign} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL reset_flags: got %b want 000", {p_rvalid, d_rvalid, p_misalign});
    end
    n_cmp++;
    if ({p_rdata, d_rdata} !== 64'h0) begin
      n_fail++; $display("[TB] FAIL reset_rdata: got %h/%h want 0/0", p_rdata, d_rdata);
    end
    n_cmp++;
    if ({p_gnt, d_gnt, mem_we, mem_addr, mem_wdata} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_port: gnt=%b%b we=%b addr=%h wd=%h want all 0",
                         p_gnt, d_gnt, mem_we, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_store_lanes();
    p_op_t  ops[6];
    p_exp_t e;
    ops[0] = mk(1, 2'd0, 0, 32'h103, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 0, 0);
    ops[1] = mk(1, 2'd1, 0, 32'h102, 32'h0000_1234, 4'b1100, 32'h1234_1234, 0, 0);
    ops[2] = mk(1, 2'd2, 0, 32'h080, 32'h8000_F0F0, 4'b1111, 32'h8000_F0F0, 0, 0);
    ops[3] = mk(1, 2'd0, 0, 32'h100, 32'h0000_005A, 4'b0001, 32'h5A5A_5A5A, 0, 0);
    ops[4] = mk(1, 2'd1, 0, 32'h084, 32'hFFFF_BEEF, 4'b0011, 32'hBEEF_BEEF, 0, 0);
    ops[5] = mk(1, 2'd0, 0, 32'h086, 32'h0000_0077, 4'b0100, 32'h7777_7777, 0, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (p_rvalid !== 1'b0) begin
        n_fail++; $display("[TB] FAIL store_idle_rvalid[%0d]: got %b want 0", i, p_rvalid);
      end
      drive_p(ops[i]);
      #1;
      n_cmp++;
      if ({p_gnt, d_gnt, mem_we, mem_addr, mem_wdata} !==
          {2'b10, ops[i].exp_we, ops[i].addr, ops[i].exp_wd}) begin
        n_fail++; $display("[TB] FAIL store_port[%0d]: gnt=%b%b we=%b addr=%h wd=%h want 10 %b %h %h",
                           i, p_gnt, d_gnt, mem_we, mem_addr, mem_wdata,
                           ops[i].exp_we, ops[i].addr, ops[i].exp_wd);
      end
      p_q.push_back(p_exp_t'{ops[i].exp_rd, ops[i].exp_mis});
      @(negedge clk);
      p_req = 1'b0;
      n_cmp++;
      if (p_rvalid !== 1'b1 || p_q.size() == 0) begin
        n_fail++; $display("[TB] FAIL store_rvalid[%0d]: got %b want 1", i, p_rvalid);
      end else begin
        e = p_q.pop_front();
        n_cmp++;
        if ({p_rdata, p_misalign} !== {e.rdata, e.mis}) begin
          n_fail++; $display("[TB] FAIL store_resp[%0d]: got %h/%b want %h/%b", i, p_rdata, p_misalign, e.rdata, e.mis);
        end
      end
    end
  endtask

  task automatic test_load_extend();
    p_op_t  ops[13];
    p_exp_t e;
    ops[0]  = mk(0, 2'd1, 0, 32'h082, 0, 0, 0, 32'hFFFF_8000, 0);
    ops[1]  = mk(0, 2'd0, 1, 32'h080, 0, 0, 0, 32'h0000_00F0, 0);
    ops[2]  = mk(0, 2'd0, 0, 32'h080, 0, 0, 0, 32'hFFFF_FFF0, 0);
    ops[3]  = mk(0, 2'd1, 1, 32'h082, 0, 0, 0, 32'h0000_8000, 0);
    ops[4]  = mk(0, 2'd2, 0, 32'h080, 0, 0, 0, 32'h8000_F0F0, 0);
    ops[5]  = mk(0, 2'd0, 1, 32'h083, 0, 0, 0, 32'h0000_0080, 0);
    ops[6]  = mk(0, 2'd0, 0, 32'h081, 0, 0, 0, 32'hFFFF_FFF0, 0);
    ops[7]  = mk(0, 2'd0, 1, 32'h100, 0, 0, 0, 32'h0000_005A, 0);
    ops[8]  = mk(0, 2'd1, 1, 32'h102, 0, 0, 0, 32'h0000_1234, 0);
    ops[9]  = mk(0, 2'd3, 0, 32'h080, 0, 0, 0, 32'h8000_F0F0, 0);
    ops[10] = mk(0, 2'd1, 0, 32'h080, 0, 0, 0, 32'hFFFF_F0F0, 0);
    ops[11] = mk(0, 2'd1, 1, 32'h084, 0, 0, 0, 32'h0000_BEEF, 0);
    ops[12] = mk(0, 2'd0, 0, 32'h086, 0, 0, 0, 32'h0000_0077, 0);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive_p(ops[i]);
      #1;
      n_cmp++;
      if ({p_gnt, d_gnt, mem_we, mem_addr} !== {2'b10, 4'b0000, ops[i].addr}) begin
        n_fail++; $display("[TB] FAIL load_port[%0d]: gnt=%b%b we=%b addr=%h want 10 0000 %h",
                           i, p_gnt, d_gnt, mem_we, mem_addr, ops[i].addr);
      end
      p_q.push_back(p_exp_t'{ops[i].exp_rd, ops[i].exp_mis});
      @(negedge clk);
      p_req = 1'b0;
      n_cmp++;
      if (p_rvalid !== 1'b1 || p_q.size() == 0) begin
        n_fail++; $display("[TB] FAIL load_rvalid[%0d]: got %b want 1", i, p_rvalid);
      end else begin
        e = p_q.pop_front();
        n_cmp++;
        if ({p_rdata, p_misalign} !== {e.rdata, e.mis}) begin
          n_fail++; $display("[TB] FAIL load_resp[%0d]: got %h/%b want %h/%b", i, p_rdata, p_misalign, e.rdata, e.mis);
        end
      end
    end
  endtask

  task automatic test_misalign();
    p_op_t  ops[6];
    p_exp_t e;
    ops[0] = mk(0, 2'd2, 0, 32'h006, 0,            0, 0, 0, 1);
    ops[1] = mk(1, 2'd1, 0, 32'h081, 32'h0000_DEAD, 0, 0, 0, 1);
    ops[2] = mk(1, 2'd2, 0, 32'h082, 32'h1111_1111, 0, 0, 0, 1);
    ops[3] = mk(0, 2'd1, 1, 32'h083, 0,            0, 0, 0, 1);
    ops[4] = mk(1, 2'd3, 0, 32'h101, 32'h2222_2222, 0, 0, 0, 1);
    ops[5] = mk(0, 2'd2, 0, 32'h080, 0,            0, 0, 32'h8000_F0F0, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_p(ops[i]);
      #1;
      n_cmp++;
      if ({p_gnt, d_gnt, mem_we} !== {2'b10, 4'b0000}) begin
        n_fail++; $display("[TB] FAIL misalign_port[%0d]: gnt=%b%b we=%b want 10 0000", i, p_gnt, d_gnt, mem_we);
      end
      p_q.push_back(p_exp_t'{ops[i].exp_rd, ops[i].exp_mis});
      @(negedge clk);
      p_req = 1'b0;
      n_cmp++;
      if (p_rvalid !== 1'b1 || p_q.size() == 0) begin
        n_fail++; $display("[TB] FAIL misalign_rvalid[%0d]: got %b want 1", i, p_rvalid);
      end else begin
        e = p_q.pop_front();
        n_cmp++;
        if ({p_rdata, p_misalign} !== {e.rdata, e.mis}) begin
          n_fail++; $display("[TB] FAIL misalign_resp[%0d]: got %h/%b want %h/%b", i, p_rdata, p_misalign, e.rdata, e.mis);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    p_op_t  ops[7];
    p_exp_t e;
    ops[0] = mk(0, 2'd2, 0, 32'h080, 0,            0,       0,            32'h8000_F0F0, 0);
    ops[1] = mk(1, 2'd0, 0, 32'h085, 32'h0000_00CC, 4'b0010, 32'hCCCC_CCCC, 0,             0);
    ops[2] = mk(0, 2'd1, 1, 32'h084, 0,            0,       0,            32'h0000_CCEF, 0);
    ops[3] = mk(0, 2'd0, 0, 32'h085, 0,            0,       0,            32'hFFFF_FFCC, 0);
    ops[4] = mk(0, 2'd0, 1, 32'h083, 0,            0,       0,            32'h0000_0080, 0);
    ops[5] = mk(1, 2'd2, 0, 32'h040, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 0,             0);
    ops[6] = mk(0, 2'd2, 0, 32'h040, 0,            0,       0,            32'hCAFE_F00D, 0);
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if (p_rvalid !== 1'b1 || p_q.size() == 0) begin
          n_fail++; $display("[TB] FAIL b2b_rvalid[%0d]: got %b want 1", i - 1, p_rvalid);
        end else begin
          e = p_q.pop_front();
          n_cmp++;
          if ({p_rdata, p_misalign} !== {e.rdata, e.mis}) begin
            n_fail++; $display("[TB] FAIL b2b_resp[%0d]: got %h/%b want %h/%b", i - 1, p_rdata, p_misalign, e.rdata, e.mis);
          end
        end
      end
      if (i == 7) begin
        p_req = 1'b0;
      end else begin
        drive_p(ops[i]);
        #1;
        n_cmp++;
        if ({p_gnt, mem_we} !== {1'b1, ops[i].exp_we}) begin
          n_fail++; $display("[TB] FAIL b2b_port[%0d]: gnt=%b we=%b want 1 %b", i, p_gnt, mem_we, ops[i].exp_we);
        end
        p_q.push_back(p_exp_t'{ops[i].exp_rd, ops[i].exp_mis});
      end
    end
    @(negedge clk);
    n_cmp++;
    if (p_rvalid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL b2b_pulse_end: got %b want 0", p_rvalid);
    end
  endtask

  task automatic test_dma();
    logic [31:0] ed;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h41; d_wdata = 32'h1234_5678;
    #1;
    n_cmp++;
    if ({p_gnt, d_gnt, mem_we, mem_addr, mem_wdata} !== {2'b01, 4'b1111, 32'h40, 32'h1234_5678}) begin
      n_fail++; $display("[TB] FAIL dma_store_port: gnt=%b%b we=%b addr=%h wd=%h want 01 1111 00000040 12345678",
                         p_gnt, d_gnt, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    d_req = 1'b0;
    n_cmp++;
    if (d_rvalid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL dma_store_no_rvalid: got %b want 0", d_rvalid);
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_wdata = '0;
    #1;
    n_cmp++;
    if ({d_gnt, mem_we, mem_addr} !== {1'b1, 4'b0000, 32'h40}) begin
      n_fail++; $display("[TB] FAIL dma_load_port: gnt=%b we=%b addr=%h want 1 0000 00000040", d_gnt, mem_we, mem_addr);
    end
    d_q.push_back(32'h1234_5678);
    @(negedge clk);
    d_req = 1'b0;
    n_cmp++;
    if (d_rvalid !== 1'b1 || d_q.size() == 0) begin
      n_fail++; $display("[TB] FAIL dma_load_rvalid: got %b want 1", d_rvalid);
    end else begin
      ed = d_q.pop_front();
      n_cmp++;
      if (d_rdata !== ed) begin
        n_fail++; $display("[TB] FAIL dma_load_data: got %h want %h", d_rdata, ed);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (d_rvalid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL dma_pulse_end: got %b want 0", d_rvalid);
    end
  endtask

  task automatic test_starvation();
    logic        exp_d, prev_p, prev_d;
    p_exp_t      e;
    logic [31:0] ed;
    prev_p = 1'b0;
    prev_d = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if ({p_rvalid, d_rvalid} !== {prev_p, prev_d}) begin
          n_fail++; $display("[TB] FAIL starve_rvalid[%0d]: got %b%b want %b%b", i - 1, p_rvalid, d_rvalid, prev_p, prev_d);
        end else if (prev_p && p_q.size() > 0) begin
          e = p_q.pop_front();
          n_cmp++;
          if (p_rdata !== e.rdata) begin
            n_fail++; $display("[TB] FAIL starve_p_data[%0d]: got %h want %h", i - 1, p_rdata, e.rdata);
          end
        end else if (prev_d && d_q.size() > 0) begin
          ed = d_q.pop_front();
          n_cmp++;
          if (d_rdata !== ed) begin
            n_fail++; $display("[TB] FAIL starve_d_data[%0d]: got %h want %h", i - 1, d_rdata, ed);
          end
        end
      end
      if (i == 10) begin
        p_req = 1'b0; d_req = 1'b0;
      end else begin
        p_req = 1'b1; p_we = 1'b0; p_size = 2'd2; p_unsigned = 1'b0; p_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h83;
        #1;
        exp_d = ((i % (STARVE_MAX + 1)) == STARVE_MAX);
        n_cmp++;
        if ({p_gnt, d_gnt} !== {~exp_d, exp_d}) begin
          n_fail++; $display("[TB] FAIL starve_grant[%0d]: got p=%b d=%b want p=%b d=%b", i, p_gnt, d_gnt, ~exp_d, exp_d);
        end
        if (exp_d) begin
          n_cmp++;
          if (mem_addr !== 32'h80) begin
            n_fail++; $display("[TB] FAIL starve_d_addr[%0d]: got %h want 00000080", i, mem_addr);
          end
          d_q.push_back(32'h8000_F0F0);
        end else begin
          p_q.push_back(p_exp_t'{32'h8000_F0F0, 1'b0});
        end
        prev_p = ~exp_d;
        prev_d = exp_d;
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({p_rvalid, d_rvalid} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL starve_pulse_end: got %b%b want 00", p_rvalid, d_rvalid);
    end
  endtask

  task automatic test_reset_mid();
    logic exp_d;
    p_q.delete();
    d_q.delete();
    @(negedge clk);
    p_req = 1'b1; p_we = 1'b0; p_size = 2'd2; p_unsigned = 1'b0; p_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({p_rvalid, d_rvalid, p_misalign, p_rdata} !== '0) begin
      n_fail++; $display("[TB] FAIL rstmid_async_drop: rv=%b%b mis=%b rdata=%h want all 0", p_rvalid, d_rvalid, p_misalign, p_rdata);
    end
    @(negedge clk);
    n_cmp++;
    if ({p_rvalid, d_rvalid} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL rstmid_held: got %b%b want 00", p_rvalid, d_rvalid);
    end
    rst_n = 1'b1;
    for (int i = 0; i <= STARVE_MAX; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_d = (i == STARVE_MAX);
      n_cmp++;
      if ({p_gnt, d_gnt} !== {~exp_d, exp_d}) begin
        n_fail++; $display("[TB] FAIL rstmid_grant[%0d]: got p=%b d=%b want p=%b d=%b", i, p_gnt, d_gnt, ~exp_d, exp_d);
      end
    end
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_store_lanes();
    test_load_extend();
    test_misalign();
    test_back_to_back();
    test_dma();
    test_starvation();
    test_reset_mid();
    n_cmp++;
    if (p_q.size() != 0 || d_q.size() != 0) begin
      n_fail++; $display("[TB] FAIL scoreboard_drain: p_q=%0d d_q=%0d want 0/0", p_q.size(), d_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
